// File: rtl/huffman_decode.sv
// huffman_decode: serial MSB-first Huffman decoder driven by a latched code table.
// Define HUFFMAN_DECODE_SYMCNT_EN to add the sym_count handshake counter output.
module huffman_decode #(
   parameter int unsigned NSYM    = 10,
   parameter int unsigned MAXLEN  = 9,
   parameter int unsigned ENTRY_W = 13
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NSYM*ENTRY_W-1:0] CODE_TABLE,
   input  logic                    table_valid,
   input  logic                    flush,
   input  logic                    bit_in,
   input  logic                    bit_valid,
   output logic                    bit_ready,
   output logic [3:0]              sym_out,
   output logic                    sym_valid,
   input  logic                    sym_ready,
   output logic                    error,
   output logic                    busy
`ifdef HUFFMAN_DECODE_SYMCNT_EN
   ,
   output logic [15:0]             sym_count
`endif
);

   localparam int unsigned LEN_W = 4;
   localparam int unsigned SYM_W = 4;
   localparam int unsigned TBL_W = NSYM * ENTRY_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [TBL_W-1:0]  table_q, table_d;
   logic [MAXLEN-2:0] acc_q, acc_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [SYM_W-1:0]  sym_out_d;
   logic              sym_valid_d, error_d;

   logic [MAXLEN-1:0] nacc, mask;
   logic [LEN_W-1:0]  nlen;
   logic              accept, hit;
   logic [SYM_W-1:0]  hit_idx;

   assign bit_ready = (state_q == S_RUN) && (!sym_valid || sym_ready);
   assign accept    = bit_valid && bit_ready;
   assign busy      = (len_q != '0);
   assign nacc      = {acc_q, bit_in};
   assign nlen      = len_q + LEN_W'(1);

   // Parallel compare of the extended prefix against every table entry; lowest index wins.
   always_comb begin
      mask    = '0;
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned b = 0; b < MAXLEN; b++) begin
         mask[b] = (LEN_W'(b) < nlen);
      end
      for (int unsigned i = 0; i < NSYM; i++) begin
         if (!hit
             && table_q[i*ENTRY_W+MAXLEN +: LEN_W] != '0
             && table_q[i*ENTRY_W+MAXLEN +: LEN_W] <= LEN_W'(MAXLEN)
             && table_q[i*ENTRY_W+MAXLEN +: LEN_W] == nlen
             && table_q[i*ENTRY_W +: MAXLEN] == (nacc & mask)) begin
            hit     = 1'b1;
            hit_idx = SYM_W'(i);
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      table_d     = table_q;
      acc_d       = acc_q;
      len_d       = len_q;
      sym_out_d   = sym_out;
      sym_valid_d = sym_valid;
      error_d     = error;
      if (sym_valid && sym_ready) sym_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (table_valid) begin
               table_d = CODE_TABLE;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (hit) begin
                  sym_out_d   = hit_idx;
                  sym_valid_d = 1'b1;
                  acc_d       = '0;
                  len_d       = '0;
               end else if (nlen < LEN_W'(MAXLEN)) begin
                  acc_d = nacc[MAXLEN-2:0];
                  len_d = nlen;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         S_ERR:   error_d = 1'b1;
         default: state_d = S_IDLE;
      endcase
      // Flush drops any partial code and pending symbol; error stays sticky.
      if (flush) begin
         state_d     = S_IDLE;
         acc_d       = '0;
         len_d       = '0;
         sym_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         table_q   <= '0;
         acc_q     <= '0;
         len_q     <= '0;
         sym_out   <= '0;
         sym_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         state_q   <= state_d;
         table_q   <= table_d;
         acc_q     <= acc_d;
         len_q     <= len_d;
         sym_out   <= sym_out_d;
         sym_valid <= sym_valid_d;
         error     <= error_d;
      end
   end

`ifdef HUFFMAN_DECODE_SYMCNT_EN
   always_ff @(posedge CLK) begin
      if (RST || flush)                sym_count <= '0;
      else if (sym_valid && sym_ready) sym_count <= sym_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_huffman_decode.sv
// tb_huffman_decode: vector table, hand sequences and randomized encode/decode against
// a bench-side code table model.
module tb_huffman_decode;

   logic         clk = 1'b0;
   logic         RST = 1'b0;
   logic [129:0] CODE_TABLE = '0;
   logic         table_valid = 1'b0;
   logic         flush = 1'b0;
   logic         bit_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         bit_ready;
   logic [3:0]   sym_out;
   logic         sym_valid;
   logic         sym_ready = 1'b1;
   logic         error;
   logic         busy;
`ifdef HUFFMAN_DECODE_SYMCNT_EN
   logic [15:0]  sym_count;
`endif

   huffman_decode dut (
      .CLK         (clk),
      .RST         (RST),
      .CODE_TABLE  (CODE_TABLE),
      .table_valid (table_valid),
      .flush       (flush),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .bit_ready   (bit_ready),
      .sym_out     (sym_out),
      .sym_valid   (sym_valid),
      .sym_ready   (sym_ready),
      .error       (error),
      .busy        (busy)
`ifdef HUFFMAN_DECODE_SYMCNT_EN
      ,
      .sym_count   (sym_count)
`endif
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] got[$];
   logic       rand_rdy = 1'b0;
   logic [3:0] tl[10];
   logic [8:0] tc[10];

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          nsym;
      logic [3:0]  syms[4];
   } vec_t;
   vec_t vecs[4];

   // Every symbol the downstream side actually takes.
   always @(negedge clk)
      if (!RST && sym_valid && sym_ready) got.push_back(sym_out);

   always @(posedge clk)
      if (rand_rdy) begin
         #1 sym_ready = 1'($urandom_range(0, 1));
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [129:0] pack_tbl();
      logic [129:0] t = '0;
      for (int i = 0; i < 10; i++) t[i*13 +: 13] = {tl[i], tc[i]};
      return t;
   endfunction

   task automatic clear_tbl();
      for (int i = 0; i < 10; i++) begin
         tl[i] = 4'd0;
         tc[i] = 9'd0;
      end
   endtask

   task automatic ref_tbl();
      clear_tbl();
      tl[0] = 4'd1; tc[0] = 9'b0;
      tl[1] = 4'd2; tc[1] = 9'b10;
      tl[2] = 4'd3; tc[2] = 9'b110;
      tl[3] = 4'd3; tc[3] = 9'b111;
   endtask

   // Complete 10-symbol prefix code (Kraft sum exactly 1).
   task automatic full_tbl();
      tl[0] = 4'd2; tc[0] = 9'b00;
      tl[1] = 4'd2; tc[1] = 9'b01;
      tl[2] = 4'd3; tc[2] = 9'b100;
      tl[3] = 4'd3; tc[3] = 9'b101;
      tl[4] = 4'd4; tc[4] = 9'b1100;
      tl[5] = 4'd4; tc[5] = 9'b1101;
      tl[6] = 4'd4; tc[6] = 9'b1110;
      tl[7] = 4'd5; tc[7] = 9'b11110;
      tl[8] = 4'd6; tc[8] = 9'b111110;
      tl[9] = 4'd6; tc[9] = 9'b111111;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      RST         = 1'b1;
      CODE_TABLE  = pack_tbl();
      table_valid = 1'b1;
      bit_valid   = 1'b0;
      flush       = 1'b0;
      @(posedge clk); #1;
      check("rst_sym_out", 32'(sym_out), 0);
      check("rst_sym_valid", 32'(sym_valid), 0);
      check("rst_error", 32'(error), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_bit_ready", 32'(bit_ready), 0);
`ifdef HUFFMAN_DECODE_SYMCNT_EN
      check("rst_sym_count", 32'(sym_count), 0);
`endif
      RST = 1'b0;
      got.delete();
   endtask

   // Presents one bit and returns just after the edge that accepts it.
   task automatic send_bit(input logic b);
      int k = 0;
      bit_in    = b;
      bit_valid = 1'b1;
      @(negedge clk);
      while (!bit_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: bit_ready stayed %0d for %0d cycles, required 1", bit_ready, k);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_code(input int s);
      for (int k = int'(tl[s]) - 1; k >= 0; k--) send_bit(tc[s][k]);
   endtask

   task automatic wait_syms(input int n);
      int k = 0;
      while (got.size() < n && k < 60) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   initial begin
      int         n;
      logic [3:0] exp_q[$];

      vecs[0] = '{16'b010110111, 9, 4, '{4'd0, 4'd1, 4'd2, 4'd3}};
      vecs[1] = '{16'b111110100, 9, 4, '{4'd3, 4'd2, 4'd1, 4'd0}};
      vecs[2] = '{16'b000,       3, 3, '{4'd0, 4'd0, 4'd0, 4'd0}};
      vecs[3] = '{16'b1010111,   7, 3, '{4'd1, 4'd1, 4'd3, 4'd0}};

      // Vector table on the reference code
      ref_tbl();
      for (int v = 0; v < 4; v++) begin
         do_reset();
         sym_ready = 1'b1;
         for (int k = vecs[v].nbits - 1; k >= 0; k--) send_bit(vecs[v].bits[k]);
         bit_valid = 1'b0;
         wait_syms(vecs[v].nsym);
         check($sformatf("vec%0d_count", v), got.size(), vecs[v].nsym);
         for (int j = 0; j < vecs[v].nsym && j < got.size(); j++)
            check($sformatf("vec%0d_sym%0d", v, j), 32'(got[j]), 32'(vecs[v].syms[j]));
      end

      // Symbol appears exactly one cycle after its final bit
      do_reset();
      send_bit(1'b0);
      check("lat_valid0", 32'(sym_valid), 1);
      check("lat_sym0", 32'(sym_out), 0);
      send_bit(1'b1);
      check("lat_valid_mid", 32'(sym_valid), 0);
      check("lat_busy_mid", 32'(busy), 1);
      send_bit(1'b0);
      check("lat_valid1", 32'(sym_valid), 1);
      check("lat_sym1", 32'(sym_out), 1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      check("lat_sym2", 32'(sym_out), 2);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      check("lat_sym3", 32'(sym_out), 3);
      bit_valid = 1'b0;

      // Output stall holds the symbol and blocks input
      do_reset();
      send_bit(1'b0);
      sym_ready = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("stall%0d_valid", c), 32'(sym_valid), 1);
         check($sformatf("stall%0d_sym", c), 32'(sym_out), 0);
         check($sformatf("stall%0d_bit_ready", c), 32'(bit_ready), 0);
         @(posedge clk); #1;
      end
      sym_ready = 1'b1;
      send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      bit_valid = 1'b0;
      wait_syms(4);
      check("stall_count", got.size(), 4);
      for (int j = 0; j < 4 && j < got.size(); j++)
         check($sformatf("stall_sym%0d", j), 32'(got[j]), j);

      // Flush mid-code, then decode after re-latch
      do_reset();
      send_bit(1'b1);
      check("flush_busy1", 32'(busy), 1);
      send_bit(1'b1);
      check("flush_busy2", 32'(busy), 1);
      bit_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy0", 32'(busy), 0);
      check("flush_idle_ready", 32'(bit_ready), 0);
      send_bit(1'b0);
      check("flush_redo_valid", 32'(sym_valid), 1);
      check("flush_redo_sym", 32'(sym_out), 0);
      // A bit accepted together with flush is discarded
      send_bit(1'b1);
      bit_in = 1'b0;
      flush  = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      bit_valid = 1'b0;
      check("flush_discard_busy", 32'(busy), 0);
      check("flush_discard_valid", 32'(sym_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      check("flush_discard_later", 32'(sym_valid), 0);

      // Reset mid-code, then a fresh decode
      do_reset();
      send_bit(1'b1); send_bit(1'b1);
      bit_valid = 1'b0;
      do_reset();
      send_bit(1'b1); send_bit(1'b0);
      bit_valid = 1'b0;
      check("rstmid_valid", 32'(sym_valid), 1);
      check("rstmid_sym", 32'(sym_out), 1);

      // Duplicate codes: lowest index wins; over-long length never matches
      clear_tbl();
      tl[0] = 4'd1;  tc[0] = 9'b0;
      tl[7] = 4'd12; tc[7] = 9'b11;
      tl[5] = 4'd2;  tc[5] = 9'b11;
      tl[2] = 4'd2;  tc[2] = 9'b11;
      do_reset();
      send_bit(1'b1); send_bit(1'b1);
      bit_valid = 1'b0;
      check("dup_valid", 32'(sym_valid), 1);
      check("dup_sym", 32'(sym_out), 2);

      // Invalid code: nine 1s with only "0" defined
      clear_tbl();
      tl[0] = 4'd1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         send_bit(1'b1);
         if (i == 7) check("err_before", 32'(error), 0);
      end
      bit_valid = 1'b0;
      check("err_set", 32'(error), 1);
      check("err_bit_ready", 32'(bit_ready), 0);
      check("err_sym_valid", 32'(sym_valid), 0);
      check("err_no_syms", got.size(), 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("err_after_flush", 32'(error), 1);
      do_reset();

      // Randomized encode -> decode, random gaps and random back-pressure
      for (int t = 0; t < 2; t++) begin
         if (t == 0) ref_tbl(); else full_tbl();
         n = 30;
         exp_q.delete();
         do_reset();
         rand_rdy = 1'b1;
         for (int i = 0; i < n; i++) begin
            int s = (t == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 9));
            exp_q.push_back(4'(s));
            send_code(s);
            if ($urandom_range(0, 2) == 0) begin
               bit_valid = 1'b0;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
         bit_valid = 1'b0;
         @(posedge clk); #2;
         rand_rdy  = 1'b0;
         sym_ready = 1'b1;
         wait_syms(n);
         check($sformatf("rand%0d_count", t), got.size(), n);
         for (int j = 0; j < n && j < got.size(); j++)
            check($sformatf("rand%0d_sym%0d", t, j), 32'(got[j]), 32'(exp_q[j]));
`ifdef HUFFMAN_DECODE_SYMCNT_EN
         check($sformatf("rand%0d_sym_count", t), 32'(sym_count), n);
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
